// File: rtl/nvram_io.sv
// rtl/nvram_io.sv - HPS ioctl bridge to the 1024x4 Williams-2 CMOS with autosave request.
module nvram_io #(
  parameter int NV_INDEX   = 4,
  parameter int ADDR_W     = 10,
  parameter int SAVE_DELAY = 120
) (
  input  logic              clock_12,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              cpu_cmos_we,
  input  logic              vblank,
  output logic              nv_sel,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_we,
  output logic [3:0]        nv_di,
  input  logic [3:0]        nv_do,
  output logic              save_req
);

  localparam int CNT_W = $clog2(SAVE_DELAY + 1);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;
  state_t state, state_nx;

  logic              hit, in_range, wr_hit, start_wr, start_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        nib_q;
  logic              range_q;
  logic              dirty;
  logic [CNT_W-1:0]  cnt;
  logic              vblank_q, upload_q, download_q;
  logic              unused_dout;

  assign unused_dout = &{1'b0, ioctl_dout[7:4]};

  assign hit      = (ioctl_index == 16'(NV_INDEX));
  assign in_range = ((ioctl_addr >> ADDR_W) == '0);
  // Download wins: a write strobe with hit blocks a same-cycle read even if the byte is dropped.
  assign wr_hit   = ioctl_download & hit & ioctl_wr;
  assign start_wr = (state == IDLE) & wr_hit & in_range;
  assign start_rd = (state == IDLE) & ~wr_hit & ioctl_upload & hit & ioctl_rd;

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_nx = WR;
        else if (start_rd) state_nx = RD_ADDR;
      end
      RD_ADDR: state_nx = RD_DATA;
      RD_DATA: state_nx = IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      nib_q      <= 4'h0;
      range_q    <= 1'b0;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'hFF;
    end else begin
      if (start_wr) begin
        addr_q <= ioctl_addr[ADDR_W-1:0];
        nib_q  <= ioctl_dout[3:0];
      end else if (start_rd) begin
        addr_q     <= ioctl_addr[ADDR_W-1:0];
        range_q    <= in_range;
        ioctl_wait <= 1'b1;
      end
      if (state == RD_DATA) begin
        ioctl_din  <= range_q ? {4'hF, nv_do} : 8'hFF;
        ioctl_wait <= 1'b0;
      end
    end
  end

  assign nv_sel  = (state != IDLE);
  assign nv_we   = (state == WR);
  assign nv_addr = addr_q;
  assign nv_di   = nib_q;

  // Later assignments win: a CPU write in the same cycle as an upload start re-marks dirty.
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      dirty      <= 1'b0;
      cnt        <= '0;
      vblank_q   <= 1'b0;
      upload_q   <= 1'b0;
      download_q <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      upload_q   <= ioctl_upload;
      download_q <= ioctl_download;
      if (dirty && vblank && !vblank_q && cnt != CNT_W'(SAVE_DELAY))
        cnt <= cnt + 1'b1;
      if (!ioctl_download && download_q && hit)
        dirty <= 1'b0;
      if (ioctl_upload && !upload_q && hit) begin
        dirty <= 1'b0;
        cnt   <= '0;
      end
      if (cpu_cmos_we && !nv_sel) begin
        dirty <= 1'b1;
        cnt   <= '0;
      end
    end
  end

  assign save_req = dirty & (cnt == CNT_W'(SAVE_DELAY)) & ~ioctl_upload;

endmodule

// File: tb/tb_nvram_io.sv
// tb/tb_nvram_io.sv - directed self-checking bench for nvram_io with a behavioural CMOS.
module tb_nvram_io;

  logic        clock_12 = 1'b0;
  logic        reset_n;
  logic        ioctl_upload, ioctl_download;
  logic [15:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd, ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_cmos_we, vblank;
  logic        nv_sel;
  logic [9:0]  nv_addr;
  logic        nv_we;
  logic [3:0]  nv_di;
  logic [3:0]  nv_do;
  logic        save_req;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] mem [1024];

  nvram_io #(.NV_INDEX(4), .ADDR_W(10), .SAVE_DELAY(3)) dut (
    .clock_12(clock_12), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .cpu_cmos_we(cpu_cmos_we), .vblank(vblank),
    .nv_sel(nv_sel), .nv_addr(nv_addr), .nv_we(nv_we), .nv_di(nv_di),
    .nv_do(nv_do), .save_req(save_req)
  );

  always #5 clock_12 = ~clock_12;

  always @(posedge clock_12) begin
    if (nv_we) mem[nv_addr] <= nv_di;
    nv_do <= mem[nv_addr];
  end

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vb();
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[5]     = 4'h9;
    mem[10'h3FF] = 4'h3;
    reset_n = 1'b0;
    ioctl_upload = 0; ioctl_download = 0; ioctl_index = 16'd4;
    ioctl_addr = '0; ioctl_rd = 0; ioctl_wr = 0; ioctl_dout = '0;
    cpu_cmos_we = 0; vblank = 0;
    tick(); tick();
    chk("rst_din", ioctl_din, 8'hFF);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_sel", nv_sel, 0);
    chk("rst_we", nv_we, 0);
    chk("rst_addr", nv_addr, 0);
    chk("rst_save", save_req, 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a read
    ioctl_upload = 1; ioctl_addr = 25'd5; ioctl_rd = 1; tick();
    ioctl_rd = 0;
    chk("mid_wait_pre", ioctl_wait, 1);
    reset_n = 1'b0; #2;
    chk("mid_wait", ioctl_wait, 0);
    chk("mid_sel", nv_sel, 0);
    chk("mid_din", ioctl_din, 8'hFF);
    reset_n = 1'b1;
    tick(); tick();
    ioctl_rd = 1; tick(); ioctl_rd = 0; tick(); tick();
    chk("mid_reread", ioctl_din, 8'hF9);
    ioctl_upload = 0; tick();

    // Download: in-range write, then out-of-range drop
    ioctl_download = 1; ioctl_addr = 25'h012; ioctl_dout = 8'hA7; ioctl_wr = 1; tick();
    ioctl_wr = 0;
    chk("dl_we", nv_we, 1);
    chk("dl_addr", nv_addr, 10'h012);
    chk("dl_di", nv_di, 4'h7);
    chk("dl_sel", nv_sel, 1);
    tick();
    chk("dl_we_drop", nv_we, 0);
    ioctl_addr = 25'h400; ioctl_dout = 8'h05; ioctl_wr = 1; tick();
    ioctl_wr = 0;
    chk("dl_oor_we", nv_we, 0);
    chk("dl_oor_sel", nv_sel, 0);
    tick();
    chk("dl_mem", mem[10'h000], 4'h0);
    ioctl_download = 0; tick();

    // Upload: readback of the downloaded nibble, top address, out-of-range
    ioctl_upload = 1; ioctl_addr = 25'h012; ioctl_rd = 1; tick(); ioctl_rd = 0;
    tick(); tick();
    chk("up_readback", ioctl_din, 8'hF7);
    ioctl_addr = 25'h3FF; ioctl_rd = 1; tick(); ioctl_rd = 0;
    chk("up_wait_n1", ioctl_wait, 1);
    chk("up_addr", nv_addr, 10'h3FF);
    tick();
    chk("up_wait_n2", ioctl_wait, 1);
    tick();
    chk("up_wait_n3", ioctl_wait, 0);
    chk("up_din", ioctl_din, 8'hF3);
    tick();
    chk("up_din_hold", ioctl_din, 8'hF3);
    ioctl_addr = 25'h400; ioctl_rd = 1; tick(); ioctl_rd = 0;
    chk("oor_wait_n1", ioctl_wait, 1);
    tick();
    chk("oor_wait_n2", ioctl_wait, 1);
    chk("oor_din_held", ioctl_din, 8'hF3);
    tick();
    chk("oor_wait_n3", ioctl_wait, 0);
    chk("oor_din", ioctl_din, 8'hFF);
    ioctl_upload = 0; tick();

    // Index mismatch
    ioctl_index = 16'd0; ioctl_download = 1; ioctl_addr = 25'h001; ioctl_wr = 1; tick();
    ioctl_wr = 0;
    chk("mis_we", nv_we, 0);
    chk("mis_sel_w", nv_sel, 0);
    ioctl_download = 0; ioctl_upload = 1; ioctl_rd = 1; tick();
    ioctl_rd = 0;
    chk("mis_wait", ioctl_wait, 0);
    chk("mis_sel_r", nv_sel, 0);
    ioctl_upload = 0; ioctl_index = 16'd4; tick();

    // Simultaneous flags: write wins, read dropped
    ioctl_upload = 1; ioctl_download = 1; ioctl_addr = 25'h020; ioctl_dout = 8'h0C;
    ioctl_wr = 1; ioctl_rd = 1; tick();
    ioctl_wr = 0; ioctl_rd = 0;
    chk("both_we", nv_we, 1);
    chk("both_wait", ioctl_wait, 0);
    tick();
    chk("both_wait2", ioctl_wait, 0);
    chk("both_mem", mem[10'h020], 4'hC);
    ioctl_upload = 0; ioctl_download = 0; tick();

    // Autosave with restart of the quiet count
    cpu_cmos_we = 1; tick(); cpu_cmos_we = 0;
    vb(); vb();
    chk("as_2vb", save_req, 0);
    cpu_cmos_we = 1; tick(); cpu_cmos_we = 0;
    vb(); vb();
    chk("as_restart", save_req, 0);
    vb();
    chk("as_fire", save_req, 1);
    vb();
    chk("as_sat", save_req, 1);
    ioctl_upload = 1; tick();
    chk("as_up_clr", save_req, 0);
    cpu_cmos_we = 1; tick(); cpu_cmos_we = 0;
    vb(); vb(); vb();
    chk("as_during_up", save_req, 0);
    ioctl_upload = 0; tick();
    chk("as_after_up", save_req, 1);
    ioctl_download = 1; tick(); ioctl_download = 0; tick();
    chk("as_dl_clr", save_req, 0);
    vb(); vb(); vb();
    chk("as_dl_stays", save_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nvram_io.md
Name: nvram_io

Overview:
- Reader/writer bridge between the HPS ioctl channel and the Williams-2 4-bit CMOS (battery RAM), 1024 x 4.
- Serves HPS upload reads, so the high-score/settings file can be saved.
- Accepts HPS download writes, so a saved file can be restored.
- Raises a save request after the CPU has modified CMOS and then left it quiet for a set number of frames.
- Sits in the core top level, beside the ROM download path, and drives a dedicated CMOS port that the game muxes in while nv_sel=1.

Parameters:
- NV_INDEX, 4: ioctl_index value that selects the NVRAM file.
- ADDR_W, 10: CMOS address width (1024 nibbles).
- SAVE_DELAY, 120: vblank rising edges of CPU write-quiet before save_req asserts.

Ports:
- clock_12  in  1  system clock, 12 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  HPS upload (save) in progress.
- ioctl_download  in  1  HPS download (restore) in progress.
- ioctl_index  in  16  file index.
- ioctl_addr  in  25  byte address.
- ioctl_rd  in  1  one-cycle read strobe.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_dout  in  8  download data.
- ioctl_din  out  8  upload data.
- ioctl_wait  out  1  stall to HPS.
- cpu_cmos_we  in  1  CPU CMOS write strobe, for dirty tracking.
- vblank  in  1  video vblank level.
- nv_sel  out  1  take CMOS port from CPU.
- nv_addr  out  ADDR_W  CMOS address.
- nv_we  out  1  CMOS write enable.
- nv_di  out  4  CMOS write data.
- nv_do  in  4  CMOS read data; 1-cycle synchronous latency.
- save_req  out  1  request HPS save.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - ioctl_din=8'hFF, ioctl_wait=0, nv_sel=0, nv_addr=0, nv_we=0, nv_di=0, save_req=0.
  - dirty=0, quiet counter=0.
  - An operation interrupted by reset is abandoned; no partial write is issued after release.
- Match qualifier: hit = (ioctl_index==NV_INDEX).
- FSM states: IDLE, RD_ADDR, RD_DATA, WR.
- IDLE:
  - ioctl_download & hit & ioctl_wr:
    - ioctl_addr < 1024: latch addr and ioctl_dout[3:0]; go to WR.
    - ioctl_addr >= 1024: byte dropped, stay in IDLE.
  - Otherwise, ioctl_upload & hit & ioctl_rd: latch addr; ioctl_wait<=1; go to RD_ADDR.
  - Download has priority if both flags are set.
- WR (1 cycle):
  - nv_sel=1, nv_we=1, nv_addr=latched addr, nv_di=latched nibble.
  - Return to IDLE; nv_we and nv_sel drop the next cycle.
  - Write latency: strobe to nv_we is 1 cycle.
- RD_ADDR: nv_sel=1, nv_addr=latched addr, nv_we=0; go to RD_DATA.
- RD_DATA:
  - Capture ioctl_din = {4'hF, nv_do} if addr < 1024, else 8'hFF (no RAM access is needed, but timing is identical).
  - ioctl_wait<=0, nv_sel<=0; go to IDLE.
  - Read: ioctl_rd at cycle N gives ioctl_wait high on N+1..N+2 and ioctl_din valid from N+3, held until the next read completes.
- Strobes arriving outside IDLE are ignored. HPS honours ioctl_wait, so none is lost in a legal flow.
- Address arithmetic: only ioctl_addr[ADDR_W-1:0] drives nv_addr. Upper bits are used only for the range check; there is no wrap.
- Dirty tracking:
  - cpu_cmos_we=1 while nv_sel=0 sets dirty=1 and clears the quiet counter.
  - Each vblank rising edge, detected with a registered copy of vblank, increments the counter while dirty=1; the counter saturates at SAVE_DELAY.
  - save_req=1 while dirty & counter==SAVE_DELAY & !ioctl_upload.
  - Rising edge of ioctl_upload with hit: dirty<=0, counter<=0, save_req<=0.
  - A CPU write during an upload sets dirty again; a new request follows once that upload ends and the delay elapses.
  - Completion of a download (ioctl_download falling with hit): dirty<=0. Restored data does not count as a change.
- cpu_cmos_we with nv_sel=1 is not counted; the game mux has blocked it.

Test Plan:
- Reset mid-read: ioctl_rd at addr 5, reset_n pulsed low during RD_ADDR -> ioctl_wait=0, nv_sel=0, ioctl_din=8'hFF immediately; the next read works normally.
- Download: index 4, write 0xA7 to addr 0x012 -> nv_we=1 one cycle later with nv_addr=0x012, nv_di=4'h7; write to addr 0x400 -> no nv_we.
- Upload: CMOS[0x3FF]=4'h3, ioctl_rd at 0x3FF -> ioctl_wait high for exactly 2 cycles, ioctl_din=8'hF3 at N+3; rd at 0x400 -> 8'hFF with the same timing.
- Index mismatch: ioctl_index=0 with wr/rd strobes -> no nv_sel, no nv_we, ioctl_wait stays 0.
- Autosave, SAVE_DELAY=3:
  - CPU write, then 3 vblanks -> save_req=1 after the 3rd rising edge.
  - Another CPU write after the 2nd vblank restarts the count.
  - ioctl_upload rising -> save_req=0.
- Simultaneous flags: upload & download both set, wr and rd in the same cycle -> WR executes and the rd is dropped (ioctl_wait stays 0).
